// File: rtl/dwt_pkg.sv
// Shared definitions for the 2-D DWT scheduler: FSM encoding, default tile
// geometry and the symmetric-extension index mapping.
package dwt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LINE_CLR,
      ST_FEED,
      ST_DRAIN,
      ST_FIN
   } state_t;

   localparam int DWT_IMG_W = 28;
   localparam int DWT_EXT   = 4;
   localparam int DWT_L     = DWT_IMG_W + 2 * DWT_EXT;

   // Whole-sample symmetric extension: edge sample is not repeated.
   function automatic int mirror_idx(input int s, input int img_w, input int ext);
      int i;
      i = s - ext;
      if (i < 0) begin
         i = -i;
      end else if (i >= img_w) begin
         i = 2 * img_w - 2 - i;
      end
      return i;
   endfunction

endpackage

// File: rtl/dwt_addr_gen.sv
// Combinational buffer address generator: maps (pass, line, index) to the
// read address and the Lo/Hi subband write addresses.
module dwt_addr_gen #(
   parameter int IMG_W  = 28,
   parameter int ADDR_W = 10
) (
   input  logic              pass,
   input  logic [ADDR_W-1:0] line,
   input  logic [ADDR_W-1:0] rd_idx,
   input  logic [ADDR_W-1:0] wr_idx,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr_lo,
   output logic [ADDR_W-1:0] wr_addr_hi
);

   localparam logic [ADDR_W-1:0] W_VEC = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] HALF  = ADDR_W'(IMG_W / 2);

   logic [ADDR_W-1:0] hi_idx;
   logic [ADDR_W-1:0] pp_line [ADDR_W];
   logic [ADDR_W-1:0] pp_rd   [ADDR_W];
   logic [ADDR_W-1:0] pp_lo   [ADDR_W];
   logic [ADDR_W-1:0] pp_hi   [ADDR_W];
   logic [ADDR_W-1:0] line_w;
   logic [ADDR_W-1:0] rd_w;
   logic [ADDR_W-1:0] lo_w;
   logic [ADDR_W-1:0] hi_w;

   assign hi_idx = wr_idx + HALF;

   // Multiply-by-IMG_W as a sum of shifted operands, one term per set bit.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_pp
         assign pp_line[gi] = W_VEC[gi] ? (line   << gi) : '0;
         assign pp_rd[gi]   = W_VEC[gi] ? (rd_idx << gi) : '0;
         assign pp_lo[gi]   = W_VEC[gi] ? (wr_idx << gi) : '0;
         assign pp_hi[gi]   = W_VEC[gi] ? (hi_idx << gi) : '0;
      end
   endgenerate

   always_comb begin
      line_w = '0;
      rd_w   = '0;
      lo_w   = '0;
      hi_w   = '0;
      for (int b = 0; b < ADDR_W; b++) begin
         line_w = line_w + pp_line[b];
         rd_w   = rd_w   + pp_rd[b];
         lo_w   = lo_w   + pp_lo[b];
         hi_w   = hi_w   + pp_hi[b];
      end
   end

   // Row pass walks along a row (line is the row); column pass transposes.
   assign rd_addr    = pass ? (rd_w + line) : (line_w + rd_idx);
   assign wr_addr_lo = pass ? (lo_w + line) : (line_w + wr_idx);
   assign wr_addr_hi = pass ? (hi_w + line) : (line_w + hi_idx);

endmodule

// File: rtl/dwt2d_sched.sv
// 2-D DWT sequencing controller: drives a shared 1-D filter over a tile,
// row pass then column pass, and issues the Lo/Hi subband writes.
module dwt2d_sched
   import dwt_pkg::*;
#(
   parameter int IMG_W  = DWT_IMG_W,
   parameter int EXT    = DWT_EXT,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              filt_clr,
   output logic              filt_in_valid,
   input  logic              filt_out_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_lo,
   output logic [ADDR_W-1:0] wr_addr_hi
);

   localparam int L  = IMG_W + 2 * EXT;
   localparam int CW = $clog2(L + 1);
   localparam int LW = $clog2(IMG_W);

   localparam logic [CW-1:0] L_CNT     = CW'(L);
   localparam logic [CW-1:0] S_LAST    = CW'(L - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(IMG_W - 1);

   state_t            state_q, state_d;
   logic [LW-1:0]     line_q, line_d;
   logic [CW-1:0]     s_q, s_d;
   logic [CW-1:0]     k_q, k_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              filt_clr_q, filt_clr_d;
   logic              fiv_q, fiv_d;

   logic [CW-1:0]     rd_s;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] wr_j;
   logic [ADDR_W-1:0] rd_addr_c;
   logic [ADDR_W-1:0] lo_c;
   logic [ADDR_W-1:0] hi_c;
   logic              count_en;
   int                c_idx;

   // Outputs past L in a line, or outside the line phases, are not counted.
   assign count_en = filt_out_valid && (k_q != L_CNT) &&
                     ((state_q == ST_FEED) || (state_q == ST_DRAIN));

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      s_d        = s_q;
      k_d        = count_en ? (k_q + 1'b1) : k_q;
      pass_d     = pass_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_en_d    = 1'b0;
      filt_clr_d = 1'b0;
      fiv_d      = rd_en_q;
      rd_s       = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LINE_CLR;
               line_d     = '0;
               pass_d     = 1'b0;
               busy_d     = 1'b1;
               filt_clr_d = 1'b1;
            end
         end
         ST_LINE_CLR: begin
            state_d = ST_FEED;
            s_d     = '0;
            k_d     = '0;
            rd_en_d = 1'b1;
            rd_s    = '0;
         end
         ST_FEED: begin
            if (s_q == S_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               s_d     = s_q + 1'b1;
               rd_en_d = 1'b1;
               rd_s    = s_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Advance in the same cycle as the last counted output.
            if (k_d == L_CNT) begin
               if (line_q != LINE_LAST) begin
                  line_d     = line_q + 1'b1;
                  state_d    = ST_LINE_CLR;
                  filt_clr_d = 1'b1;
               end else if (!pass_q) begin
                  pass_d     = 1'b1;
                  line_d     = '0;
                  state_d    = ST_LINE_CLR;
                  filt_clr_d = 1'b1;
               end else begin
                  state_d = ST_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign rd_idx = ADDR_W'(mirror_idx(int'(rd_s), IMG_W, EXT));

   always_comb begin
      rd_addr_d = rd_en_d ? rd_addr_c : '0;
   end

   assign c_idx = int'(k_q) - 2 * EXT;
   assign wr_j  = ADDR_W'(c_idx / 2);
   assign wr_en = count_en && (c_idx >= 0) && (c_idx < IMG_W) && (c_idx[0] == 1'b0);

   dwt_addr_gen #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .pass       (pass_q),
      .line       (ADDR_W'(line_q)),
      .rd_idx     (rd_idx),
      .wr_idx     (wr_j),
      .rd_addr    (rd_addr_c),
      .wr_addr_lo (lo_c),
      .wr_addr_hi (hi_c)
   );

   assign wr_addr_lo = wr_en ? lo_c : '0;
   assign wr_addr_hi = wr_en ? hi_c : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         line_q     <= '0;
         s_q        <= '0;
         k_q        <= '0;
         pass_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         filt_clr_q <= 1'b0;
         fiv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         s_q        <= s_d;
         k_q        <= k_d;
         pass_q     <= pass_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         filt_clr_q <= filt_clr_d;
         fiv_q      <= fiv_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign rd_en         = rd_en_q;
   assign rd_addr       = rd_addr_q;
   assign filt_clr      = filt_clr_q;
   assign filt_in_valid = fiv_q;

endmodule
